// File: rtl/huffman_merge_ctrl.sv
// rtl/huffman_merge_ctrl.sv - six-symbol Huffman merge sequencer driving a shared external sorter
module huffman_merge_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [47:0] cnt_in,
    output logic [47:0] in_Aid_all,
    output logic [47:0] in_CNT_all,
    input  logic [47:0] out_Aid_all,
    input  logic [47:0] out_CNT_all,
    output logic        busy,
    output logic        merge_valid,
    output logic [7:0]  merge_a,
    output logic [7:0]  merge_b,
    output logic [7:0]  merge_id,
    output logic [7:0]  merge_cnt,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SORT  = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0] state_q, state_d;
    logic [7:0] aid_q [6];
    logic [7:0] aid_d [6];
    logic [7:0] cnt_q [6];
    logic [7:0] cnt_d [6];
    logic [2:0] n_q, n_d;
    logic [2:0] round_q, round_d;
    logic       mv_q, mv_d;
    logic [7:0] ma_q, ma_d, mb_q, mb_d, mid_q, mid_d, mcnt_q, mcnt_d;

    logic [2:0] lo_idx, hi_idx;
    logic [8:0] sum9;
    logic [7:0] sum_sat;
    logic [7:0] new_id;
    logic       any_zero;

    // The two smallest live nodes always sit in the last two live slots after a sort.
    assign lo_idx  = n_q - 3'd1;
    assign hi_idx  = n_q - 3'd2;
    assign sum9    = {1'b0, cnt_q[lo_idx]} + {1'b0, cnt_q[hi_idx]};
    assign sum_sat = sum9[8] ? 8'hFF : sum9[7:0];
    assign new_id  = 8'd7 + {5'd0, round_q};

    always_comb begin
        any_zero = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (cnt_in[47-8*i -: 8] == 8'd0) begin
                any_zero = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        aid_d   = aid_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        round_d = round_q;
        mv_d    = 1'b0;
        ma_d    = ma_q;
        mb_d    = mb_q;
        mid_d   = mid_q;
        mcnt_d  = mcnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (any_zero) begin
                        state_d = S_ERR;
                    end else begin
                        for (int i = 0; i < 6; i++) begin
                            aid_d[i] = 8'(i + 1);
                            cnt_d[i] = cnt_in[47-8*i -: 8];
                        end
                        n_d     = 3'd6;
                        round_d = 3'd0;
                        state_d = S_SORT;
                    end
                end
            end
            S_SORT: begin
                for (int i = 0; i < 6; i++) begin
                    aid_d[i] = out_Aid_all[47-8*i -: 8];
                    cnt_d[i] = out_CNT_all[47-8*i -: 8];
                end
                state_d = S_MERGE;
            end
            S_MERGE: begin
                mv_d            = 1'b1;
                ma_d            = aid_q[lo_idx];
                mb_d            = aid_q[hi_idx];
                mid_d           = new_id;
                mcnt_d          = sum_sat;
                aid_d[hi_idx]   = new_id;
                cnt_d[hi_idx]   = sum_sat;
                aid_d[lo_idx]   = 8'd0;
                cnt_d[lo_idx]   = 8'd0;
                n_d             = n_q - 3'd1;
                round_d         = round_q + 3'd1;
                state_d         = (round_q == 3'd4) ? S_DONE : S_SORT;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            for (int i = 0; i < 6; i++) begin
                aid_q[i] <= 8'd0;
                cnt_q[i] <= 8'd0;
            end
            n_q     <= 3'd0;
            round_q <= 3'd0;
            mv_q    <= 1'b0;
            ma_q    <= 8'd0;
            mb_q    <= 8'd0;
            mid_q   <= 8'd0;
            mcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            aid_q   <= aid_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            round_q <= round_d;
            mv_q    <= mv_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            mid_q   <= mid_d;
            mcnt_q  <= mcnt_d;
        end
    end

    always_comb begin
        in_Aid_all = '0;
        in_CNT_all = '0;
        for (int i = 0; i < 6; i++) begin
            in_Aid_all[47-8*i -: 8] = aid_q[i];
            in_CNT_all[47-8*i -: 8] = cnt_q[i];
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE) || (state_q == S_ERR);
    assign err         = (state_q == S_ERR);
    assign merge_valid = mv_q;
    assign merge_a     = ma_q;
    assign merge_b     = mb_q;
    assign merge_id    = mid_q;
    assign merge_cnt   = mcnt_q;

endmodule

// File: doc/huffman_merge_ctrl.md
HUFFMAN_MERGE_CTRL -- requirements
Module: huffman_merge_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high; sampled on rising clk edge.
REQ-003 SHALL have: start  input  1  one-cycle request to begin a merge run; honoured only in IDLE.
REQ-004 SHALL have: cnt_in  input  48  six 8-bit symbol counts; symbol 1 at [47:40] ... symbol 6 at [7:0]; sampled with start.
REQ-005 SHALL have: in_Aid_all, in_CNT_all  output  48 each  vectors to the shared combinational sorter; slot i at [47-8i -: 8], i=0..5.
REQ-006 SHALL have: out_Aid_all, out_CNT_all  input  48 each  sorter result, descending by count, slot 0 = largest.
REQ-007 SHALL have: busy  output  1  high while not IDLE.
REQ-008 SHALL have: merge_valid  output  1  one-cycle pulse per merge record.
REQ-009 SHALL have: merge_a, merge_b, merge_id, merge_cnt  output  8 each  smallest node ID, second-smallest node ID, new node ID, merged count.
REQ-010 SHALL have: done  output  1  one-cycle pulse ending a run; err  output  1  high with done when run is rejected.

Function
REQ-011 States SHALL be IDLE, SORT, MERGE, DONE, ERR; busy = (state != IDLE).
REQ-012 IDLE + start: if any count in cnt_in is 0 -> ERR; else load CNT regs from cnt_in, Aid regs 1..6, live count n=6, round=0 -> SORT.
REQ-013 ERR SHALL last one cycle with done=1, err=1, no merge_valid, then -> IDLE.
REQ-014 in_Aid_all/in_CNT_all SHALL be driven directly from Aid/CNT regs at all times; dead slots hold Aid=0, CNT=0.
REQ-015 SORT (1 cycle): capture out_Aid_all/out_CNT_all into regs at cycle end -> MERGE.
REQ-016 MERGE (1 cycle): register merge_a=Aid[n-1], merge_b=Aid[n-2], merge_id=7+round, merge_cnt=CNT[n-1]+CNT[n-2]; merge_valid high the following cycle only.
REQ-017 MERGE SHALL write slot n-2 := {merge_id, merge_cnt}, slot n-1 := {0,0}, n := n-1, round := round+1.
REQ-018 Sum SHALL be computed at 9 bits and saturated to 8'hFF.
REQ-019 MERGE with round==4 SHALL go to DONE, else to SORT; exactly 5 merges per run, IDs 7..11 in order.
REQ-020 DONE SHALL last one cycle with done=1, err=0, coincident with the 5th merge_valid, then -> IDLE.
REQ-021 Timing: start sampled at edge 0 -> merge_valid in cycles 3,5,7,9,11; done in cycle 11; busy high cycles 1..11; IDLE cycle 12.
REQ-022 start while busy SHALL be ignored; start held high SHALL launch a new run from the first IDLE cycle.
REQ-023 Tie ordering SHALL be left to the sorter; the controller uses slot position only.

Reset
REQ-024 reset SHALL force IDLE next cycle: busy, done, err, merge_valid, merge_a/b/id/cnt = 0; Aid/CNT regs (hence in_Aid_all/in_CNT_all) = 0; n=0; round=0.
REQ-025 reset mid-run SHALL discard partial results; no done or merge_valid may follow it.
REQ-026 reset and start in the same cycle: reset wins; start is dropped.

Verification
REQ-027 cnt_in = 40,30,20,8,5,2 -> merges (a,b,id,cnt) = (6,5,7,7),(7,4,8,15),(8,3,9,35),(2,9,10,65),(1,10,11,105); done cycle 11, err=0.
REQ-028 cnt_in = 200,150,40,20,10,1 -> (6,5,7,11),(7,4,8,31),(8,3,9,71),(9,2,10,221),(1,10,11,255 saturated).
REQ-029 cnt_in with symbol 3 = 0 -> cycle 1: done=1, err=1, busy=1; no merge_valid; IDLE in cycle 2.
REQ-030 reset asserted in cycle 6 of a run -> cycle 7: all outputs 0, busy=0; no further merge_valid; a fresh start then completes normally.
REQ-031 start held high for 30 cycles -> runs begin at edges 0 and 12 and the next run starts at edge 24; start pulses during busy do not alter results; reset+start same cycle -> no run.
